// File: rtl/jump_pkg.sv
// Shared constants and the RAS operation decode for the ID-stage jump logic.
package jump_pkg;

    localparam int FW_MEM    = 0;
    localparam int FW_EX     = 1;
    localparam int REGION_HI = 31;
    localparam int REGION_LO = 28;

    typedef enum logic [1:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_e;

    // A push+pop on an empty stack degenerates to a plain push; a pop on empty is a no-op.
    function automatic ras_op_e ras_op(input logic push, input logic pop, input logic nonempty);
        if (push && pop && nonempty) return RAS_REPL;
        if (push)                    return RAS_PUSH;
        if (pop && nonempty)         return RAS_POP;
        return RAS_IDLE;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with push/pop/replace and a sticky overflow flag.
// Latency: top/valid combinational from state; state updates on the rising edge.
// Backpressure: none; the caller gates push/pop with its own update enable.
module ras_stack #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   top,
    output logic          valid,
    output logic [CW-1:0] count,
    output logic          overflow
);
    import jump_pkg::*;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full;

    assign top_ptr  = wr_ptr_q - PW'(1);
    assign valid    = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign top      = valid ? mem_q[top_ptr] : 32'h0;
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (ras_op(push, pop, valid))
            RAS_PUSH: begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                // When full the write lands on the oldest slot, so depth stays put.
                if (full) overflow_d = 1'b1;
                else      count_d    = count_q + CW'(1);
            end
            RAS_POP: begin
                wr_ptr_d = top_ptr;
                count_d  = count_q - CW'(1);
            end
            RAS_REPL: begin
                mem_d[top_ptr] = wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/jump_ras_unit.sv
// ID-stage jump target resolution with forwarding mux, RAS prediction and hit/miss stats.
// Latency: jump_addr/ras_top/mispredict combinational; stack and counters update next edge.
// Backpressure: stall or flush suppresses every state update for that cycle.
module jump_ras_unit #(
    parameter int DEPTH     = 8,
    parameter int FWD_SRC   = 2,
    parameter int PC_REGION = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       jr,
    input  logic                       jal,
    input  logic                       rs_is_ra,
    input  logic [31:0]                rs,
    input  logic [25:0]                target,
    input  logic [31:0]                pc_plus4,
    input  logic [31:0]                ret_addr,
    input  logic [FWD_SRC-1:0]         fw_sel,
    input  logic [32*FWD_SRC-1:0]      fw_data,
    output logic [31:0]                jump_addr,
    output logic [31:0]                ras_top,
    output logic                       ras_valid,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     ras_count,
    output logic                       ras_overflow,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [CNT_W-1:0]           miss_cnt
);
    import jump_pkg::*;

    logic [31:0]      rsv;
    logic [3:0]       region;
    logic             upd;
    logic             pop_evt;
    logic             pred_hit;
    logic             unused_pc;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    // Later (younger) sources override older ones, giving highest-set-bit priority.
    always_comb begin
        rsv = rs;
        for (int i = 0; i < FWD_SRC; i++) begin
            if (fw_sel[i]) rsv = fw_data[32*i +: 32];
        end
    end

    assign region    = (PC_REGION != 0) ? pc_plus4[REGION_HI:REGION_LO] : 4'b0;
    assign unused_pc = ^pc_plus4[REGION_LO-1:0];
    assign jump_addr = jr ? rsv : {region, target, 2'b00};

    assign upd        = !stall && !flush;
    assign pop_evt    = jr && rs_is_ra;
    assign pred_hit   = ras_valid && (rsv == ras_top);
    assign mispredict = pop_evt && ras_valid && (rsv != ras_top);

    ras_stack #(.DEPTH(DEPTH)) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (jal && upd),
        .pop      (pop_evt && upd),
        .wdata    (ret_addr),
        .top      (ras_top),
        .valid    (ras_valid),
        .count    (ras_count),
        .overflow (ras_overflow)
    );

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd && pop_evt) begin
            if (pred_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_jump_ras_unit.sv
// Scoreboard bench for jump_ras_unit: stimulus queues expected outputs, a negedge monitor checks them.
module tb_jump_ras_unit;
    import jump_pkg::*;

    localparam int DEPTH = 8;
    localparam int FWD   = 2;
    localparam int CW    = 16;

    typedef enum int {F_JUMP, F_JUMP0, F_TOP, F_VALID, F_MISP, F_COUNT, F_OVF, F_HIT, F_MISS} field_e;
    typedef struct {
        field_e      f;
        logic [31:0] v;
        string       nm;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   stall, flush, jr, jal, rs_is_ra;
    logic [31:0]            rs, pc_plus4, ret_addr;
    logic [25:0]            target;
    logic [FWD-1:0]         fw_sel;
    logic [32*FWD-1:0]      fw_data;
    logic [31:0]            jump_addr, ras_top;
    logic                   ras_valid, mispredict, ras_overflow;
    logic [$clog2(DEPTH):0] ras_count;
    logic [CW-1:0]          hit_cnt, miss_cnt;

    logic [31:0]            jump_addr0;
    logic [31:0]            unused_top0;
    logic                   unused_valid0, unused_misp0, unused_ovf0;
    logic [$clog2(DEPTH):0] unused_count0;
    logic [CW-1:0]          unused_hit0, unused_miss0;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    jump_ras_unit #(.DEPTH(DEPTH), .FWD_SRC(FWD), .PC_REGION(1), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .jr(jr), .jal(jal),
        .rs_is_ra(rs_is_ra), .rs(rs), .target(target), .pc_plus4(pc_plus4),
        .ret_addr(ret_addr), .fw_sel(fw_sel), .fw_data(fw_data),
        .jump_addr(jump_addr), .ras_top(ras_top), .ras_valid(ras_valid),
        .mispredict(mispredict), .ras_count(ras_count), .ras_overflow(ras_overflow),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    jump_ras_unit #(.DEPTH(DEPTH), .FWD_SRC(FWD), .PC_REGION(0), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .jr(jr), .jal(jal),
        .rs_is_ra(rs_is_ra), .rs(rs), .target(target), .pc_plus4(pc_plus4),
        .ret_addr(ret_addr), .fw_sel(fw_sel), .fw_data(fw_data),
        .jump_addr(jump_addr0), .ras_top(unused_top0), .ras_valid(unused_valid0),
        .mispredict(unused_misp0), .ras_count(unused_count0), .ras_overflow(unused_ovf0),
        .hit_cnt(unused_hit0), .miss_cnt(unused_miss0)
    );

    function automatic logic [31:0] actual(input field_e f);
        case (f)
            F_JUMP:  return jump_addr;
            F_JUMP0: return jump_addr0;
            F_TOP:   return ras_top;
            F_VALID: return {31'b0, ras_valid};
            F_MISP:  return {31'b0, mispredict};
            F_COUNT: return 32'(ras_count);
            F_OVF:   return {31'b0, ras_overflow};
            F_HIT:   return 32'(hit_cnt);
            F_MISS:  return 32'(miss_cnt);
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: drains every expectation queued for this cycle at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.f);
            tests++;
            if (a !== e.v) begin
                failed++;
                $display("FAIL %s: got %h expected %h at %0t", e.nm, a, e.v, $time);
            end
        end
    end

    task automatic expect_val(input field_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.f = f; e.v = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic idle();
        stall = 0; flush = 0; jr = 0; jal = 0; rs_is_ra = 0;
        rs = '0; target = '0; pc_plus4 = '0; ret_addr = '0;
        fw_sel = '0; fw_data = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ra(input logic [31:0] v);
        idle(); jal = 1; ret_addr = v;
        cyc();
    endtask

    task automatic pop_ra(input logic [31:0] r);
        idle(); jr = 1; rs_is_ra = 1; rs = r;
    endtask

    initial begin
        rst_n = 1'b1;
        idle();
        #2;
        // Reset held while a push is requested
        rst_n = 1'b0; jal = 1; ret_addr = 32'h0040_0010;
        #1;
        expect_val(F_VALID, 0, "rst_valid");
        expect_val(F_TOP,   0, "rst_top");
        expect_val(F_HIT,   0, "rst_hit");
        expect_val(F_COUNT, 0, "rst_count");
        expect_val(F_MISP,  0, "rst_misp");
        cyc();
        rst_n = 1'b1;
        cyc();
        idle();
        expect_val(F_TOP,   32'h0040_0010, "post_rst_top");
        expect_val(F_COUNT, 1,             "post_rst_count");
        expect_val(F_VALID, 1,             "post_rst_valid");

        // Forwarding priority
        jr = 1; rs = 32'h3000; fw_sel = 2'b11;
        fw_data[32*FW_EX +: 32]  = 32'h1000;
        fw_data[32*FW_MEM +: 32] = 32'h2000;
        expect_val(F_JUMP, 32'h1000, "fw_both");
        expect_val(F_MISP, 0,        "fw_no_misp");
        cyc();
        fw_sel = 2'b00;
        expect_val(F_JUMP, 32'h3000, "fw_none");
        cyc();
        fw_sel = 2'b01;
        expect_val(F_JUMP, 32'h2000, "fw_mem");
        cyc();

        // Region formation, both parameterisations
        idle(); target = 26'h40; pc_plus4 = 32'hA000_0000;
        expect_val(F_JUMP,  32'hA000_0100, "region1");
        expect_val(F_JUMP0, 32'h0000_0100, "region0");
        cyc();

        // Drain the reset-test entry with a hit
        pop_ra(32'h0040_0010);
        expect_val(F_MISP, 0, "drain_misp");
        cyc();
        push_ra(32'h0040_0020);
        pop_ra(32'h0040_0020);
        expect_val(F_MISP,  0,             "hit_misp");
        expect_val(F_TOP,   32'h0040_0020, "hit_top");
        expect_val(F_COUNT, 1,             "hit_count_pre");
        cyc();
        idle();
        expect_val(F_HIT,   2, "hit_cnt");
        expect_val(F_COUNT, 0, "hit_count_post");
        expect_val(F_VALID, 0, "hit_valid_post");
        expect_val(F_TOP,   0, "hit_top_empty");
        push_ra(32'h0040_0020);
        pop_ra(32'h0040_0024);
        expect_val(F_MISP, 1,             "miss_misp");
        expect_val(F_JUMP, 32'h0040_0024, "miss_jump");
        cyc();
        idle();
        expect_val(F_MISS,  1, "miss_cnt");
        expect_val(F_HIT,   2, "miss_hit_same");
        expect_val(F_COUNT, 0, "miss_count");

        // Overflow and pointer wrap
        for (int i = 1; i <= 9; i++) push_ra(32'(i));
        idle();
        expect_val(F_COUNT, 8, "ovf_count");
        expect_val(F_OVF,   1, "ovf_flag");
        expect_val(F_TOP,   9, "ovf_top");
        for (int k = 0; k < 8; k++) begin
            pop_ra(32'(9 - k));
            expect_val(F_TOP,  32'(9 - k), "wrap_top");
            expect_val(F_MISP, 0,          "wrap_misp");
            cyc();
        end
        idle();
        expect_val(F_VALID, 0, "wrap_empty");
        expect_val(F_HIT,   10, "wrap_hits");
        pop_ra(32'h0);
        expect_val(F_MISP, 0, "empty_pop_misp");
        cyc();
        idle();
        expect_val(F_COUNT, 0, "empty_pop_count");
        expect_val(F_MISS,  2, "empty_pop_miss");

        // Stall holds state
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1; jal = 1; ret_addr = 32'h55;
            expect_val(F_COUNT, 0, "stall_count");
            cyc();
        end
        idle();
        expect_val(F_COUNT, 0, "stall_after");
        expect_val(F_TOP,   0, "stall_top");

        // Flush suppresses pop and stats
        push_ra(32'h10);
        pop_ra(32'h10); flush = 1;
        expect_val(F_MISP,  0, "flush_misp");
        expect_val(F_COUNT, 1, "flush_count_pre");
        cyc();
        idle();
        expect_val(F_COUNT, 1,     "flush_count");
        expect_val(F_HIT,   10,    "flush_hit");
        expect_val(F_TOP,   32'h10, "flush_top");
        pop_ra(32'h99); flush = 1; stall = 1;
        expect_val(F_MISP, 1, "stflush_misp");
        cyc();
        idle();
        expect_val(F_MISS,  2, "stflush_miss");
        expect_val(F_COUNT, 1, "stflush_count");

        // Simultaneous push+pop replaces top
        pop_ra(32'h10); jal = 1; ret_addr = 32'h20;
        expect_val(F_MISP, 0, "repl_misp");
        cyc();
        idle();
        expect_val(F_TOP,   32'h20, "repl_top");
        expect_val(F_COUNT, 1,      "repl_count");
        expect_val(F_HIT,   11,     "repl_hit");
        expect_val(F_OVF,   1,      "ovf_sticky");
        cyc();

        // Asynchronous reset mid-sequence
        rst_n = 1'b0;
        #1;
        expect_val(F_COUNT, 0, "arst_count");
        expect_val(F_TOP,   0, "arst_top");
        expect_val(F_OVF,   0, "arst_ovf");
        expect_val(F_HIT,   0, "arst_hit");
        expect_val(F_MISS,  0, "arst_miss");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/jump_ras_unit.md
# jump_ras_unit

Parametrised successor to the ID-stage jump-address logic. Resolves `j`/`jal`/`jr`/`jalr` targets, with an N-source forwarding mux for the register operand. Adds a circular return-address stack (RAS) that predicts `jr $ra` targets and flags mispredictions. Saturating hit/miss counters support performance analysis. Sits in ID, beside the hazard unit and PC-select mux.

## Interface
- `DEPTH`, 8: RAS entries; power of two, ≥2.
- `FWD_SRC`, 2: number of forwarding sources. Index `FWD_SRC-1` is the youngest stage (EX); index 0 is the oldest (MEM, …).
- `PC_REGION`, 1: 1 → upper 4 target bits come from `pc_plus4[31:28]`; 0 → upper 4 bits are zero (legacy).
- `CNT_W`, 16: width of each statistics counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: ID held; no state update.
- `flush` in 1: ID instruction squashed; no state update.
- `jr` in 1: register jump (`jr` or `jalr`) in ID.
- `jal` in 1: link instruction (`jal` or `jalr`) in ID; push request.
- `rs_is_ra` in 1: the `jr` source register is $31.
- `rs` in 32: register-file RD1.
- `target` in 26: J-format target field.
- `pc_plus4` in 32: PC+4 of the ID instruction.
- `ret_addr` in 32: link address to push.
- `fw_sel` in FWD_SRC: one-hot forwarding select; all-zero means no forwarding.
- `fw_data` in 32*FWD_SRC: forwarded values; slice i is `[32*i+31:32*i]`.
- `jump_addr` out 32: resolved jump target.
- `ras_top` out 32: current top-of-stack prediction.
- `ras_valid` out 1: stack non-empty.
- `mispredict` out 1: resolved `jr $ra` target ≠ `ras_top`.
- `ras_count` out $clog2(DEPTH)+1: number of valid entries.
- `ras_overflow` out 1: sticky; set when a push overwrites the oldest entry.
- `hit_cnt`, `miss_cnt` out CNT_W each: saturating statistics counters.

## Operation
- **Resolved operand `rsv`:** `fw_data` slice of the highest set bit of `fw_sel`; `rs` if `fw_sel` is zero. A non-one-hot `fw_sel` resolves by priority and is not an error.
- **Jump target:** `jump_addr = jr ? rsv : {region, target, 2'b00}`. `region` is `pc_plus4[31:28]` if `PC_REGION`, else `4'b0`.
- **Pop event:** `jr && rs_is_ra`. **Push event:** `jal`.
- An update is enabled when `upd = !stall && !flush`.
- **Push only:** write `ret_addr` at `wr_ptr`; `wr_ptr++` mod DEPTH; `count++`.
  - If `count == DEPTH` (full), the oldest entry is overwritten, `count` stays DEPTH, and `ras_overflow` is set.
- **Pop only:** `wr_ptr--`; `count--`.
  - Pop on empty: no pointer or count change.
- **Push + pop together** (`jalr $ra, $ra`): the top entry is replaced with `ret_addr`; pointer and count are unchanged. On empty, this behaves as a push.
- `ras_top = mem[wr_ptr-1]`; it is 0 when empty.
- **Prediction outcome** (pop events only, gated by `upd`):
  - `ras_valid && rsv == ras_top` → `hit_cnt++`.
  - Any other pop → `miss_cnt++`.
  - Both counters saturate at all-ones.
- `mispredict = jr && rs_is_ra && ras_valid && rsv != ras_top`. It is not gated by `stall`/`flush`; the hazard unit qualifies it.
- Forwarding bubbles are the hazard unit's responsibility. While `stall` holds an instruction, repeated cycles must not pop or count more than once; `upd` guarantees this.

## Timing
- `jump_addr`, `ras_top`, `ras_valid`, `mispredict`: combinational, same cycle as the inputs.
- Stack, pointers, `ras_count`, `ras_overflow`, and counters update on the rising `clk` edge when `upd`. Their effects are visible the next cycle.
- **Reset (asynchronous, `rst_n` low):**
  - `wr_ptr`, `count`, all entries, `ras_overflow`, `hit_cnt`, `miss_cnt` → 0.
  - Hence `ras_top = 0`, `ras_valid = 0`, `ras_count = 0`, `mispredict = 0`.
  - Reset mid-sequence discards all state immediately.
- `flush` and `stall` high together: no update.
- Pointer wrap-around: DEPTH−1 → 0 on push, 0 → DEPTH−1 on pop.

## Structure
- Shared `jump_pkg`: fw-source index constants (`FW_EX`, `FW_MEM`), `REGION_HI = 31`, `REGION_LO = 28`.
- Sub-module `ras_stack` (parameter DEPTH) contains:
  - pointer/count logic, storage, the push/pop/replace rules, and the overflow flag.
  - ports: `clk`, `rst_n`, `push`, `pop`, `wdata`, `top`, `valid`, `count`, `overflow`.
- The top level holds the forwarding mux, target formation, comparison, and counters.

## Test plan
- **Reset defaults:** with `rst_n` low, then `jal=1`, `ret_addr=0x400010` for 1 cycle → while reset: `ras_valid=0`, `ras_top=0`, `hit_cnt=0`. After reset and the edge: `ras_top=0x400010`, `ras_count=1`.
- **Forwarding priority:** FWD_SRC=2, `jr=1`, `fw_sel=2'b11`, EX data `0x1000`, MEM data `0x2000`, `rs=0x3000` → `jump_addr=0x1000`. With `fw_sel=00` → `0x3000`.
- **Region:** `target=0x0000040`, `pc_plus4=0xA0000000`. PC_REGION=1 → `0xA0000100`; PC_REGION=0 → `0x00000100`.
- **Push/pop hit and mispredict:**
  - push `0x400020`, then `jr $ra` with `rs=0x400020` → `mispredict=0`, `hit_cnt=1`, `ras_count=0`.
  - repeat with `rs=0x400024` → `mispredict=1`, `miss_cnt=1`.
- **Overflow and wrap:** DEPTH=8; push values 1..9 → `ras_count=8`, `ras_overflow=1`, `ras_top=9`. Pop 8 times → tops are 9..2, then `ras_valid=0`. A 9th pop leaves `count=0` and increments `miss_cnt`.
- **Stall/flush and simultaneous ops:**
  - `jal` held for 3 cycles with `stall=1` → `ras_count` unchanged.
  - `flush=1` with `jr $ra` → no pop, no count.
  - `jal` + `jr $ra` together with top `0x10` and `ret_addr=0x20` → `ras_top=0x20`, `ras_count` unchanged.
